// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register chain of DEPTH elastic stages with misalignment squash and flush.
// Optional input skid buffer enabled by defining MEM_WB_PIPE_SKID_BUF_EN.
module mem_wb_pipe #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 30,
    parameter int EXP_W      = 3,
    parameter int EXP_NONE   = 0,
    parameter int EXP_MISS   = 2,
    parameter int DEPTH      = 2,
    parameter int CTRL_OP_W  = 2,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_NOP   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  miss_align,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_W-1:0]       in_pc,
    input  logic [CTRL_OP_W-1:0]  in_ctrl_op,
    input  logic [REG_ADDR_W-1:0] in_dst_addr,
    input  logic                  in_gpr_we_,
    input  logic                  in_br_flag,
    input  logic [EXP_W-1:0]      in_exp_code,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_W-1:0]       out_pc,
    output logic [CTRL_OP_W-1:0]  out_ctrl_op,
    output logic [REG_ADDR_W-1:0] out_dst_addr,
    output logic                  out_gpr_we_,
    output logic                  out_br_flag,
    output logic [EXP_W-1:0]      out_exp_code,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            occupancy
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // valid never waits on ready, and an offered beat holds until it moves.

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [CTRL_OP_W-1:0]  ctrl_op;
        logic [REG_ADDR_W-1:0] dst_addr;
        logic                  gpr_we_;
        logic                  br_flag;
        logic [EXP_W-1:0]      exp_code;
        logic [DATA_W-1:0]     data;
    } beat_t;

    localparam beat_t RST_BEAT = '{
        pc:       '0,
        ctrl_op:  CTRL_OP_W'(CTRL_NOP),
        dst_addr: '0,
        gpr_we_:  1'b1,
        br_flag:  1'b0,
        exp_code: EXP_W'(EXP_NONE),
        data:     '0
    };

    beat_t            stg_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] ld;
    beat_t            in_beat;
    beat_t            src;
    logic             src_vld;
    logic             accept;
    logic [2:0]       skid_cnt;

    // A stage loads when it is empty or its occupant moves on; walk from the output back.
    always_comb begin : ld_chain
        logic carry;
        carry = out_ready;
        ld    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            ld[k] = !vld_q[k] || carry;
            carry = ld[k];
        end
    end

    always_comb begin
        in_beat = '{
            pc:       in_pc,
            ctrl_op:  in_ctrl_op,
            dst_addr: in_dst_addr,
            gpr_we_:  in_gpr_we_,
            br_flag:  in_br_flag,
            exp_code: in_exp_code,
            data:     in_data
        };
        if (miss_align) begin
            in_beat.ctrl_op  = CTRL_OP_W'(CTRL_NOP);
            in_beat.dst_addr = '0;
            in_beat.gpr_we_  = 1'b1;
            in_beat.exp_code = EXP_W'(EXP_MISS);
            in_beat.data     = '0;
        end
    end

`ifdef MEM_WB_PIPE_SKID_BUF_EN
    beat_t skid_q;
    logic  skid_vld_q;

    // Skid only fills when every stage is full and stalled, so ready is just "skid empty".
    assign in_ready = !skid_vld_q;
    assign accept   = in_valid && in_ready && !flush;
    assign src_vld  = skid_vld_q || accept;
    assign src      = skid_vld_q ? skid_q : in_beat;
    assign skid_cnt = 3'(skid_vld_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_vld_q <= 1'b0;
            skid_q     <= RST_BEAT;
        end else if (flush || (skid_vld_q && ld[0])) begin
            skid_vld_q <= 1'b0;
            skid_q     <= RST_BEAT;
        end else if (accept && !ld[0]) begin
            skid_vld_q <= 1'b1;
            skid_q     <= in_beat;
        end
    end
`else
    assign in_ready = ld[0] && !flush;
    assign accept   = in_valid && in_ready;
    assign src_vld  = accept;
    assign src      = in_beat;
    assign skid_cnt = 3'd0;
`endif

    // Empty stages always carry RST_BEAT so the output bus idles at reset values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) stg_q[k] <= RST_BEAT;
        end else if (flush) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) stg_q[k] <= RST_BEAT;
        end else begin
            if (ld[0]) begin
                vld_q[0] <= src_vld;
                stg_q[0] <= src_vld ? src : RST_BEAT;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (ld[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    stg_q[k] <= stg_q[k-1];
                end
            end
        end
    end

    always_comb begin
        occupancy = skid_cnt;
        for (int k = 0; k < DEPTH; k++) occupancy = occupancy + 3'(vld_q[k]);
    end

    assign out_valid    = vld_q[DEPTH-1];
    assign out_pc       = stg_q[DEPTH-1].pc;
    assign out_ctrl_op  = stg_q[DEPTH-1].ctrl_op;
    assign out_dst_addr = stg_q[DEPTH-1].dst_addr;
    assign out_gpr_we_  = stg_q[DEPTH-1].gpr_we_;
    assign out_br_flag  = stg_q[DEPTH-1].br_flag;
    assign out_exp_code = stg_q[DEPTH-1].exp_code;
    assign out_data     = stg_q[DEPTH-1].data;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Randomized bench for mem_wb_pipe: FIFO-level reference model plus directed scenarios.
module tb_mem_wb_pipe;

  localparam int DATA_W     = 32;
  localparam int PC_W       = 30;
  localparam int EXP_W      = 3;
  localparam int DEPTH      = 2;
  localparam int CTRL_OP_W  = 2;
  localparam int REG_ADDR_W = 5;
`ifdef MEM_WB_PIPE_SKID_BUF_EN
  localparam bit SKID = 1'b1;
  localparam int CAP  = DEPTH + 1;
`else
  localparam bit SKID = 1'b0;
  localparam int CAP  = DEPTH;
`endif
  localparam int BW = PC_W + CTRL_OP_W + REG_ADDR_W + 1 + 1 + EXP_W + DATA_W;
  localparam logic [BW-1:0] RST_BEAT =
    {PC_W'(0), CTRL_OP_W'(0), REG_ADDR_W'(0), 1'b1, 1'b0, EXP_W'(0), DATA_W'(0)};

  logic                  clk, reset, flush, miss_align;
  logic                  in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]       in_pc, out_pc;
  logic [CTRL_OP_W-1:0]  in_ctrl_op, out_ctrl_op;
  logic [REG_ADDR_W-1:0] in_dst_addr, out_dst_addr;
  logic                  in_gpr_we_, out_gpr_we_, in_br_flag, out_br_flag;
  logic [EXP_W-1:0]      in_exp_code, out_exp_code;
  logic [DATA_W-1:0]     in_data, out_data;
  logic [2:0]            occupancy;
  logic [BW-1:0]         out_vec;

  assign out_vec = {out_pc, out_ctrl_op, out_dst_addr, out_gpr_we_, out_br_flag, out_exp_code, out_data};

  mem_wb_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .miss_align(miss_align),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ctrl_op(in_ctrl_op), .in_dst_addr(in_dst_addr),
    .in_gpr_we_(in_gpr_we_), .in_br_flag(in_br_flag),
    .in_exp_code(in_exp_code), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl_op(out_ctrl_op), .out_dst_addr(out_dst_addr),
    .out_gpr_we_(out_gpr_we_), .out_br_flag(out_br_flag),
    .out_exp_code(out_exp_code), .out_data(out_data),
    .occupancy(occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  // exp_q holds accepted beats in order; enter_q holds the edge each beat entered
  // the register chain (-1 while parked in the skid entry).
  logic [BW-1:0] exp_q[$];
  int            enter_q[$];
  int            edge_n = 0;
  int            n_cmp  = 0;
  int            n_mis  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] stored_beat();
    if (miss_align)
      return {in_pc, CTRL_OP_W'(0), REG_ADDR_W'(0), 1'b1, in_br_flag, EXP_W'(2), DATA_W'(0)};
    return {in_pc, in_ctrl_op, in_dst_addr, in_gpr_we_, in_br_flag, in_exp_code, in_data};
  endfunction

  // Oldest beat is never obstructed, so it shows DEPTH-1 edges after entering the chain.
  function automatic bit exp_out_valid();
    return exp_q.size() > 0 && enter_q[0] >= 0 && (edge_n - enter_q[0] >= DEPTH - 1);
  endfunction

  function automatic bit exp_in_ready();
    if (SKID) return exp_q.size() < CAP;
    return !flush && (exp_q.size() < DEPTH || out_ready);
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    enter_q.delete();
  endfunction

  // One clock: compare on the falling edge, then advance the model on the rising edge.
  task automatic step();
    bit            ov, ir, ixf, oxf;
    logic [BW-1:0] nb;
    @(negedge clk);
    ov = exp_out_valid();
    ir = exp_in_ready();
    check("out_valid", out_valid, ov);
    check("occupancy", occupancy, exp_q.size());
    check("in_ready", in_ready, ir);
    check("out_beat", out_vec, ov ? exp_q[0] : RST_BEAT);
    ixf = in_valid && ir && !flush;
    oxf = ov && out_ready;
    nb  = stored_beat();
    @(posedge clk);
    edge_n++;
    if (flush) model_clear();
    else begin
      if (oxf) begin
        void'(exp_q.pop_front());
        void'(enter_q.pop_front());
        foreach (enter_q[i]) if (enter_q[i] < 0) enter_q[i] = edge_n;
      end
      if (ixf) begin
        enter_q.push_back(exp_q.size() >= DEPTH ? -1 : edge_n);
        exp_q.push_back(nb);
      end
    end
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic set_beat(input logic iv, input logic [PC_W-1:0] pc, input logic miss);
    in_valid    = iv;
    in_pc       = pc;
    miss_align  = miss;
    in_ctrl_op  = CTRL_OP_W'($urandom);
    in_dst_addr = REG_ADDR_W'($urandom);
    in_gpr_we_  = 1'($urandom);
    in_br_flag  = 1'($urandom);
    in_exp_code = EXP_W'($urandom);
    in_data     = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_beat(1'b0, '0, 1'b0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_beat", out_vec, RST_BEAT);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream with downstream always ready.
    for (int i = 0; i < 4; i++) begin
      set_beat(1'b1, PC_W'(32'h10 + i), 1'b0);
      step();
    end
    set_beat(1'b0, '0, 1'b0);
    repeat (DEPTH + 2) step();

    // Misaligned beat is squashed except pc and branch flag.
    set_beat(1'b1, PC_W'(32'h55), 1'b1);
    in_gpr_we_ = 1'b0; in_dst_addr = 5'd7; in_data = 32'hDEADBEEF; in_exp_code = 3'd0;
    step();
    set_beat(1'b0, '0, 1'b0);
    repeat (DEPTH - 1) step();
    check("miss_valid", out_valid, 1);
    check("miss_gpr_we_", out_gpr_we_, 1);
    check("miss_dst", out_dst_addr, 0);
    check("miss_data", out_data, 0);
    check("miss_exp", out_exp_code, 2);
    check("miss_pc", out_pc, 32'h55);
    repeat (2) step();

    // Fill while stalled, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < CAP + 2; i++) begin
      set_beat(1'b1, PC_W'($urandom), 1'b0);
      step();
    end
    check("full_in_ready", in_ready, 0);
    check("full_occupancy", occupancy, CAP);
    out_ready = 1'b1;
    set_beat(1'b0, '0, 1'b0);
    repeat (CAP + DEPTH + 1) step();

    // Flush at occupancy 2 with a beat offered.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_beat(1'b1, PC_W'($urandom), 1'b0);
      step();
    end
    flush = 1'b1;
    set_beat(1'b1, PC_W'(32'h77), 1'b0);
    step();
    flush = 1'b0;
    set_beat(1'b0, '0, 1'b0);
    check("flush_out_valid", out_valid, 0);
    check("flush_occupancy", occupancy, 0);
    out_ready = 1'b1;
    step();

    // Asynchronous reset between edges with occupancy 2.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_beat(1'b1, PC_W'($urandom), 1'b0);
      step();
    end
    set_beat(1'b0, '0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_occupancy", occupancy, 0);
    check("arst_out_beat", out_vec, RST_BEAT);
    model_clear();
    @(posedge clk); #2 reset = 1'b1;
    out_ready = 1'b1;
    set_beat(1'b1, PC_W'(32'h99), 1'b0);
    step();
    set_beat(1'b0, '0, 1'b0);
    repeat (DEPTH + 1) step();

    // Random traffic.
    repeat (800) begin
      set_beat($urandom_range(0, 3) != 0, PC_W'($urandom), $urandom_range(0, 4) == 0);
      out_ready = $urandom_range(0, 9) < 6;
      flush     = $urandom_range(0, 49) == 0;
      step();
    end
    flush = 1'b0; out_ready = 1'b1;
    set_beat(1'b0, '0, 1'b0);
    repeat (CAP + DEPTH + 1) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result/load data width.
REQ-002 SHALL have parameter PC_W, default 30, word-address PC width.
REQ-003 SHALL have parameter EXP_W, default 3, exception-code width; EXP_NONE default 0, EXP_MISS default 2.
REQ-004 SHALL have parameter DEPTH, default 2, legal 1..4, number of register stages.
REQ-005 SHALL have parameters CTRL_OP_W default 2 and REG_ADDR_W default 5; CTRL_NOP value 0.
REQ-006 Ports, one per line:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- miss_align  in  1  misalignment flag qualifying the current input beat.
- in_valid / in_ready  in / out  1 / 1  upstream handshake.
- in_pc, in_ctrl_op, in_dst_addr  in  PC_W, CTRL_OP_W, REG_ADDR_W  upstream payload.
- in_gpr_we_, in_br_flag  in  1  active-low GPR write enable, branch flag.
- in_exp_code, in_data  in  EXP_W, DATA_W  upstream payload.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- out_pc, out_ctrl_op, out_dst_addr, out_gpr_we_, out_br_flag, out_exp_code, out_data  out  as inputs  registered payload.
- occupancy  out  3  count of valid entries held.

Function
REQ-007 Input beat SHALL transfer when in_valid and in_ready are both high at a rising edge; output beat SHALL transfer when out_valid and out_ready are both high.
REQ-008 Each stage SHALL hold one valid bit and one payload; stage k SHALL load from stage k-1 when stage k is empty or its contents advance in the same cycle.
REQ-009 Latency SHALL be DEPTH cycles from input transfer to out_valid with out_ready held high; throughput SHALL be one beat per cycle.
REQ-010 When out_ready is low with out_valid high, all out_* SHALL remain stable; bubbles upstream SHALL still collapse.
REQ-011 A transferred beat with miss_align high SHALL be stored with ctrl_op=CTRL_NOP, dst_addr=0, gpr_we_=1, exp_code=EXP_MISS, data=0, and pc and br_flag passed unchanged.
REQ-012 flush high at an edge SHALL clear every valid bit and payload to reset values; no input beat SHALL be accepted that cycle; flush SHALL override miss_align and the handshakes.
REQ-013 Empty stages SHALL hold reset payload values; out_* SHALL equal reset values whenever out_valid is low.
REQ-014 Occupancy SHALL equal the number of valid entries, updated on the same edge as the transfer; simultaneous in and out transfers SHALL leave it unchanged.
REQ-015 At full capacity with out_ready low, in_ready SHALL be low and no data SHALL be overwritten or dropped.

Reset
REQ-016 With reset low, all valid bits SHALL clear immediately (asynchronously), independent of clk.
REQ-017 During reset, outputs SHALL be: out_valid=0, out_pc=0, out_ctrl_op=CTRL_NOP, out_dst_addr=0, out_gpr_we_=1, out_br_flag=0, out_exp_code=EXP_NONE, out_data=0, occupancy=0.
REQ-018 Reset asserted mid-transfer SHALL discard all in-flight beats; the first edge after release SHALL be able to accept input.

Configuration
REQ-019 With macro MEM_WB_PIPE_SKID_BUF_EN defined, the block SHALL add a one-entry skid buffer at the input; capacity SHALL be DEPTH+1; in_ready SHALL be driven only from flops (no combinational path from out_ready).
REQ-020 With the macro undefined, capacity SHALL be DEPTH; in_ready SHALL be high when stage 0 is empty or stage 0 advances this cycle, and may depend combinationally on out_ready.

Verification
REQ-021 DEPTH=2, out_ready=1, beats pc=0x10..0x13 on consecutive cycles -> out_valid from cycle 2, pc 0x10..0x13 in order, one per cycle, occupancy steady at 2.
REQ-022 A beat with in_gpr_we_=0, dst=7, data=0xDEADBEEF, miss_align=1 -> output gpr_we_=1, dst=0, data=0, exp_code=2, pc unchanged.
REQ-023 Fill with out_ready=0 -> in_ready low at occupancy 2 (no skid) or 3 (skid); payload held; release out_ready -> all beats drain in order.
REQ-024 flush with occupancy 2 and in_valid high -> next cycle out_valid=0, occupancy=0, incoming beat not accepted.
REQ-025 reset pulled low asynchronously between edges with occupancy 2 -> out_valid=0 and occupancy=0 before the next edge; normal flow resumes after release.
